// File: rtl/result_router.sv
// Read side of the shared slave->master result FIFO: pops one entry at a time,
// steers it to the master channel named by its source tag and counts frame words.
module result_router #(
  parameter int DW        = 32,
  parameter int PW        = 8,
  parameter int FRAME_LEN = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fifo_empty,
  output logic              fifo_rd_en,
  input  logic [DW+PW+2:0]  fifo_rd_data,
  output logic [DW-1:0]     mstr0_data,
  output logic [1:0]        mstr0_mode,
  output logic [PW-1:0]     mstr0_proc_val,
  output logic              mstr0_valid,
  input  logic              mstr0_ready,
  output logic              mstr0_cmplt,
  output logic [DW-1:0]     mstr1_data,
  output logic [1:0]        mstr1_mode,
  output logic [PW-1:0]     mstr1_proc_val,
  output logic              mstr1_valid,
  input  logic              mstr1_ready,
  output logic              mstr1_cmplt,
  output logic              busy
);

  localparam int CW = $clog2(FRAME_LEN + 1);

  typedef enum logic [1:0] {IDLE, WAIT, SEND} state_t;

  state_t          r_state;
  logic            r_ch;
  logic [DW-1:0]   r_data     [2];
  logic [1:0]      r_mode     [2];
  logic [PW-1:0]   r_proc_val [2];
  logic [1:0]      r_valid;
  logic [1:0]      r_cmplt;
  logic [CW-1:0]   r_cnt      [2];

  logic            w_src;
  logic [1:0]      w_mode;
  logic [PW-1:0]   w_proc_val;
  logic [DW-1:0]   w_data;
  logic [1:0]      w_ready;
  logic            w_hs;

  assign w_src      = fifo_rd_data[DW+PW+2];
  assign w_mode     = fifo_rd_data[DW+PW+1 -: 2];
  assign w_proc_val = fifo_rd_data[DW+PW-1 -: PW];
  assign w_data     = fifo_rd_data[DW-1:0];
  assign w_ready    = {mstr1_ready, mstr0_ready};

  // Valid is only ever set while in SEND, so state plus ready defines the handshake.
  assign w_hs = (r_state == SEND) && w_ready[r_ch];

  // The pop is combinational so a freshly non-empty FIFO reaches a channel in 2 cycles
  // and back-to-back words stream at 1 per 2 cycles.
  assign fifo_rd_en = !rst && !fifo_empty && ((r_state == IDLE) || w_hs);
  assign busy       = (r_state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_ch    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (!fifo_empty) r_state <= WAIT;
        WAIT: begin
          if (w_mode == 2'd0) begin
            r_state <= IDLE;
          end else begin
            r_ch    <= w_src;
            r_state <= SEND;
          end
        end
        SEND: if (w_hs) r_state <= fifo_empty ? IDLE : WAIT;
        default: r_state <= IDLE;
      endcase
    end
  end

  for (genvar gi = 0; gi < 2; gi++) begin : g_chan
    always_ff @(posedge clk) begin
      if (rst) begin
        r_data[gi]     <= '0;
        r_mode[gi]     <= '0;
        r_proc_val[gi] <= '0;
        r_valid[gi]    <= 1'b0;
        r_cmplt[gi]    <= 1'b0;
        r_cnt[gi]      <= '0;
      end else begin
        r_cmplt[gi] <= 1'b0;
        if ((r_state == WAIT) && (w_mode != 2'd0) && (w_src == 1'(gi))) begin
          r_data[gi]     <= w_data;
          r_mode[gi]     <= w_mode;
          r_proc_val[gi] <= w_proc_val;
          r_valid[gi]    <= 1'b1;
        end else if (w_hs && (r_ch == 1'(gi))) begin
          r_valid[gi] <= 1'b0;
          // The last word of a frame restarts the count and fires the completion pulse.
          if (r_cnt[gi] == CW'(FRAME_LEN - 1)) begin
            r_cnt[gi]   <= '0;
            r_cmplt[gi] <= 1'b1;
          end else begin
            r_cnt[gi] <= r_cnt[gi] + 1'b1;
          end
        end
      end
    end
  end

  assign mstr0_data     = r_data[0];
  assign mstr0_mode     = r_mode[0];
  assign mstr0_proc_val = r_proc_val[0];
  assign mstr0_valid    = r_valid[0];
  assign mstr0_cmplt    = r_cmplt[0];
  assign mstr1_data     = r_data[1];
  assign mstr1_mode     = r_mode[1];
  assign mstr1_proc_val = r_proc_val[1];
  assign mstr1_valid    = r_valid[1];
  assign mstr1_cmplt    = r_cmplt[1];

endmodule
